// File: rtl/la_trigger_engine.sv
// Trigger engine for the logic analyser: per-channel edge/level qualifiers combined
// in OR / AND-ACC / AND-COIN / SEQ modes, with occurrence count, holdoff and timestamp.
module la_trigger_engine #(
    parameter int unsigned CH_NUM = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned TS_W   = 24
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  arm,
    input  logic                  disarm,
    input  logic [CH_NUM-1:0]     probe_in,
    input  logic [3*CH_NUM-1:0]   cfg_code,
    input  logic [1:0]            cfg_mode,
    input  logic [CNT_W-1:0]      cfg_count,
    input  logic [CNT_W-1:0]      cfg_holdoff,
    output logic                  armed,
    output logic                  trig_pulse,
    output logic                  triggered,
    output logic [CNT_W-1:0]      event_cnt,
    output logic [TS_W-1:0]       trig_time
);

    localparam int unsigned PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    localparam logic [1:0] MODE_OR   = 2'd0;
    localparam logic [1:0] MODE_ACC  = 2'd1;
    localparam logic [1:0] MODE_COIN = 2'd2;
    localparam logic [1:0] MODE_SEQ  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_HOLDOFF, S_SEARCH, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [CH_NUM-1:0]     s1, s2, s3;
    logic [3*CH_NUM-1:0]   code_q;
    logic [1:0]            mode_q;
    logic [CNT_W-1:0]      count_q, holdoff_q, hold_cnt;
    logic [CH_NUM-1:0]     sticky;
    logic [PTR_W-1:0]      seq_ptr, seq_exp;
    logic                  seq_found, seq_more, seq_hit;
    logic                  evt_c, evt_q;
    logic [TS_W-1:0]       ts_cnt, ts_inc;
    logic [CNT_W-1:0]      cnt_inc, count_n;
    logic [CH_NUM-1:0]     en, edge_ch, hit;
    logic                  restart, searching;
    logic                  armed_d, trig_pulse_d, triggered_d;
    logic [CNT_W-1:0]      event_cnt_d;
    logic [TS_W-1:0]       trig_time_d;

    // A simultaneous disarm wins over arm
    assign restart   = arm & ~disarm;
    assign searching = (state == S_SEARCH) & ~arm & ~disarm;
    assign cnt_inc   = (&event_cnt) ? event_cnt : event_cnt + CNT_W'(1);
    assign ts_inc    = (&ts_cnt) ? ts_cnt : ts_cnt + TS_W'(1);
    assign count_n   = (count_q == '0) ? CNT_W'(1) : count_q;

    // Per-channel qualifier: odd codes enable, bit2 selects level, bit1 selects falling/low
    always_comb begin
        en      = '0;
        edge_ch = '0;
        hit     = '0;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            en[i]      = code_q[3*i];
            edge_ch[i] = code_q[3*i] & ~code_q[3*i+2];
            hit[i]     = code_q[3*i] & (code_q[3*i+2]
                         ? (code_q[3*i+1] ? ~s2[i] : s2[i])
                         : (code_q[3*i+1] ? (~s2[i] & s3[i]) : (s2[i] & ~s3[i])));
        end
    end

    // Sequence pointer names the lowest enabled channel at or above it
    always_comb begin
        seq_exp   = '0;
        seq_found = 1'b0;
        seq_more  = 1'b0;
        for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
            if (en[i] && (PTR_W'(i) >= seq_ptr)) begin
                seq_exp   = PTR_W'(i);
                seq_found = 1'b1;
            end
        end
        for (int i = 0; i < int'(CH_NUM); i++) begin
            if (en[i] && (PTR_W'(i) > seq_exp)) seq_more = 1'b1;
        end
        seq_hit = seq_found & hit[seq_exp];
    end

    always_comb begin
        evt_c = 1'b0;
        case (mode_q)
            MODE_OR:   evt_c = |hit;
            MODE_ACC:  evt_c = (|en) & (&(sticky | hit | ~en));
            MODE_COIN: evt_c = (|en) & (&(hit | ~en));
            MODE_SEQ:  evt_c = seq_hit & ~seq_more;
            default:   evt_c = 1'b0;
        endcase
    end

    // Synchronisers, latched configuration and event pipeline
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            code_q    <= '0;
            mode_q    <= '0;
            count_q   <= '0;
            holdoff_q <= '0;
            hold_cnt  <= '0;
            sticky    <= '0;
            seq_ptr   <= '0;
            evt_q     <= 1'b0;
            ts_cnt    <= '0;
        end else begin
            s1 <= probe_in;
            s2 <= s1;
            s3 <= s2;
            if (restart) begin
                code_q    <= cfg_code;
                mode_q    <= cfg_mode;
                count_q   <= cfg_count;
                holdoff_q <= cfg_holdoff;
                hold_cnt  <= CNT_W'(1);
                sticky    <= '0;
                seq_ptr   <= '0;
                evt_q     <= 1'b0;
                ts_cnt    <= '0;
            end else begin
                evt_q <= searching & evt_c;
                if (searching) begin
                    sticky <= evt_c ? '0 : (sticky | (hit & edge_ch));
                    if (mode_q == MODE_SEQ && seq_hit)
                        seq_ptr <= seq_more ? (seq_exp + PTR_W'(1)) : '0;
                end
                if (state == S_HOLDOFF && hold_cnt != holdoff_q)
                    hold_cnt <= hold_cnt + CNT_W'(1);
                if (state == S_HOLDOFF || state == S_SEARCH)
                    ts_cnt <= ts_inc;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            trig_pulse <= 1'b0;
            triggered  <= 1'b0;
            event_cnt  <= '0;
            trig_time  <= '0;
        end else begin
            state      <= state_nxt;
            armed      <= armed_d;
            trig_pulse <= trig_pulse_d;
            triggered  <= triggered_d;
            event_cnt  <= event_cnt_d;
            trig_time  <= trig_time_d;
        end
    end

    always_comb begin
        state_nxt = state;
        if (disarm) begin
            state_nxt = S_IDLE;
        end else if (arm) begin
            state_nxt = (cfg_holdoff == '0) ? S_SEARCH : S_HOLDOFF;
        end else begin
            case (state)
                S_HOLDOFF: if (hold_cnt == holdoff_q) state_nxt = S_SEARCH;
                S_SEARCH:  if (evt_q && cnt_inc == count_n) state_nxt = S_DONE;
                default:   state_nxt = state;
            endcase
        end
    end

    always_comb begin
        armed_d      = (state_nxt == S_HOLDOFF) || (state_nxt == S_SEARCH);
        triggered_d  = (state_nxt == S_DONE);
        trig_pulse_d = (state == S_SEARCH) && (state_nxt == S_DONE);
        event_cnt_d  = event_cnt;
        trig_time_d  = trig_time;
        if (restart)
            event_cnt_d = '0;
        else if (searching && evt_q)
            event_cnt_d = cnt_inc;
        if (trig_pulse_d)
            trig_time_d = ts_inc;
    end

endmodule

// File: tb/tb_la_trigger_engine.sv
// Directed bench for la_trigger_engine; trigger pulses are scored against
// expectations queued at the moment the stimulus is driven.
module tb_la_trigger_engine;

    localparam int unsigned CH_NUM = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TS_W   = 24;

    logic                sys_clk = 1'b0;
    logic                sys_rst = 1'b1;
    logic                arm = 1'b0;
    logic                disarm = 1'b0;
    logic [CH_NUM-1:0]   probe_in = '0;
    logic [3*CH_NUM-1:0] cfg_code = '0;
    logic [1:0]          cfg_mode = '0;
    logic [CNT_W-1:0]    cfg_count = '0;
    logic [CNT_W-1:0]    cfg_holdoff = '0;
    logic                armed, trig_pulse, triggered;
    logic [CNT_W-1:0]    event_cnt;
    logic [TS_W-1:0]     trig_time;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int arm_cyc = 0;

    typedef struct {
        int               cyc;
        logic [CNT_W-1:0] cnt;
        logic [TS_W-1:0]  ts;
        logic             trg;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t obs_q[$];
    pulse_t mon_p;

    la_trigger_engine #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .arm(arm), .disarm(disarm),
        .probe_in(probe_in), .cfg_code(cfg_code), .cfg_mode(cfg_mode),
        .cfg_count(cfg_count), .cfg_holdoff(cfg_holdoff),
        .armed(armed), .trig_pulse(trig_pulse), .triggered(triggered),
        .event_cnt(event_cnt), .trig_time(trig_time)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (trig_pulse === 1'b1) begin
            mon_p.cyc = cyc;
            mon_p.cnt = event_cnt;
            mon_p.ts  = trig_time;
            mon_p.trg = triggered;
            obs_q.push_back(mon_p);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge sys_clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Config is scrambled right after arm: the engine must use the latched copy
    task automatic do_arm(input logic [3*CH_NUM-1:0] code, input logic [1:0] mode,
                          input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] hold);
        cfg_code = code; cfg_mode = mode; cfg_count = cnt; cfg_holdoff = hold;
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        arm_cyc = cyc;
        cfg_code = ~code; cfg_mode = ~mode; cfg_count = cnt + 16'd5; cfg_holdoff = hold + 16'd7;
    endtask

    task automatic expect_pulse(input int drive_cyc, input logic [CNT_W-1:0] cnt);
        pulse_t p;
        p.cyc = drive_cyc + 4;
        p.cnt = cnt;
        p.ts  = TS_W'(drive_cyc + 4 - arm_cyc);
        p.trg = 1'b1;
        exp_q.push_back(p);
    endtask

    task automatic pulse_ch(input int ch, output int drive_cyc);
        probe_in[ch] = 1'b1;
        drive_cyc = cyc;
        tick(2);
        probe_in[ch] = 1'b0;
        tick(3);
    endtask

    task automatic sb_drain(input string tag);
        pulse_t e, o;
        check({tag, "_pulses"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_cycle"}, 64'(o.cyc), 64'(e.cyc));
            check({tag, "_event_cnt"}, 64'(o.cnt), 64'(e.cnt));
            check({tag, "_trig_time"}, 64'(o.ts), 64'(e.ts));
            check({tag, "_triggered"}, 64'(o.trg), 64'(e.trg));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    function automatic logic [3*CH_NUM-1:0] code_for(input int ch, input logic [2:0] c,
                                                     input logic [3*CH_NUM-1:0] base);
        logic [3*CH_NUM-1:0] r;
        r = base;
        r[3*ch +: 3] = c;
        return r;
    endfunction

    initial begin
        int d;
        logic [3*CH_NUM-1:0] code;

        tick(3);
        check("rst_armed", 64'(armed), 64'd0);
        check("rst_trig_pulse", 64'(trig_pulse), 64'd0);
        check("rst_triggered", 64'(triggered), 64'd0);
        check("rst_event_cnt", 64'(event_cnt), 64'd0);
        check("rst_trig_time", 64'(trig_time), 64'd0);
        sys_rst = 1'b0;
        tick(4);

        // OR, rising on CH0 / falling on CH1
        code = code_for(1, 3'b011, code_for(0, 3'b001, '0));
        do_arm(code, 2'd0, 16'd1, 16'd0);
        check("or_armed", 64'(armed), 64'd1);
        tick(5);
        probe_in[0] = 1'b1;
        d = cyc;
        expect_pulse(d, 16'd1);
        tick(8);
        check("or_triggered", 64'(triggered), 64'd1);
        check("or_armed_low", 64'(armed), 64'd0);
        check("or_event_cnt", 64'(event_cnt), 64'd1);
        sb_drain("or");

        // AND-ACC: CH0 rising is remembered until CH1 falls
        probe_in = '0;
        probe_in[1] = 1'b1;
        tick(5);
        do_arm(code, 2'd1, 16'd1, 16'd0);
        tick(3);
        probe_in[0] = 1'b1;
        tick(100);
        check("acc_no_trig", 64'(triggered), 64'd0);
        check("acc_cnt0", 64'(event_cnt), 64'd0);
        probe_in[1] = 1'b0;
        d = cyc;
        expect_pulse(d, 16'd1);
        tick(8);
        check("acc_triggered", 64'(triggered), 64'd1);
        sb_drain("acc");

        // AND-COIN: staggered rises miss, simultaneous rises hit
        probe_in = '0;
        tick(5);
        code = code_for(1, 3'b001, code_for(0, 3'b001, '0));
        do_arm(code, 2'd2, 16'd1, 16'd0);
        tick(3);
        probe_in[0] = 1'b1;
        tick(2);
        probe_in[1] = 1'b1;
        tick(8);
        check("coin_stagger", 64'(triggered), 64'd0);
        probe_in = '0;
        tick(7);
        probe_in[1:0] = 2'b11;
        d = cyc;
        expect_pulse(d, 16'd1);
        tick(8);
        check("coin_triggered", 64'(triggered), 64'd1);
        sb_drain("coin");

        // SEQ over CH2, CH5, CH6: order 5,2,6,5,6 fires only on the last pulse
        probe_in = '0;
        tick(5);
        code = code_for(6, 3'b001, code_for(5, 3'b001, code_for(2, 3'b001, '0)));
        do_arm(code, 2'd3, 16'd1, 16'd0);
        tick(3);
        pulse_ch(5, d);
        pulse_ch(2, d);
        pulse_ch(6, d);
        pulse_ch(5, d);
        check("seq_early", 64'(triggered), 64'd0);
        pulse_ch(6, d);
        expect_pulse(d, 16'd1);
        tick(4);
        check("seq_triggered", 64'(triggered), 64'd1);
        sb_drain("seq");

        // Count 3 with holdoff 50: the edge at +10 is discarded
        code = code_for(0, 3'b001, '0);
        do_arm(code, 2'd0, 16'd3, 16'd50);
        wait_until(arm_cyc + 10);
        pulse_ch(0, d);
        wait_until(arm_cyc + 20);
        check("hold_armed", 64'(armed), 64'd1);
        wait_until(arm_cyc + 60);
        pulse_ch(0, d);
        wait_until(arm_cyc + 75);
        check("hold_cnt1", 64'(event_cnt), 64'd1);
        check("hold_not_done", 64'(triggered), 64'd0);
        wait_until(arm_cyc + 80);
        pulse_ch(0, d);
        wait_until(arm_cyc + 100);
        pulse_ch(0, d);
        expect_pulse(d, 16'd3);
        tick(4);
        check("hold_event_cnt", 64'(event_cnt), 64'd3);
        check("hold_triggered", 64'(triggered), 64'd1);
        sb_drain("hold");

        // disarm beats arm; reset mid-search clears everything at once
        arm = 1'b1;
        disarm = 1'b1;
        tick(1);
        arm = 1'b0;
        disarm = 1'b0;
        check("prio_armed", 64'(armed), 64'd0);
        check("prio_triggered", 64'(triggered), 64'd0);
        do_arm(code, 2'd0, 16'd1, 16'd0);
        tick(5);
        check("rst2_armed_pre", 64'(armed), 64'd1);
        sys_rst = 1'b1;
        #1;
        check("rst2_armed", 64'(armed), 64'd0);
        check("rst2_triggered", 64'(triggered), 64'd0);
        check("rst2_event_cnt", 64'(event_cnt), 64'd0);
        check("rst2_trig_time", 64'(trig_time), 64'd0);
        tick(2);
        sys_rst = 1'b0;
        tick(3);
        probe_in[0] = 1'b1;
        tick(8);
        check("rst2_no_trig", 64'(triggered), 64'd0);
        sb_drain("rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
